// File: rtl/rename_map_pkg.sv
// Shared types and sizes for the 2-wide rename stage.
//   arch_reg_t    : architectural register index
//   phys_reg_t    : physical register index
//   rename_slot_t : one renamed slot as held in the output register
package rename_map_pkg;

  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned ARCH_REGS            = 32;
  localparam int unsigned ARCH_REGS_ADDR_WIDTH = 5;
  localparam int unsigned PHYS_REGS            = 64;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
  localparam int unsigned FREE_CNT_WIDTH       = 7;
  localparam int unsigned RAT_RD_PORTS         = 6;

  typedef logic [ARCH_REGS_ADDR_WIDTH-1:0] arch_reg_t;
  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;

  typedef struct packed {
    phys_reg_t prs1;
    phys_reg_t prs2;
    phys_reg_t prd;
    phys_reg_t stale_prd;
    logic      alloc;
  } rename_slot_t;

endpackage

// File: rtl/rename_map_rat.sv
// Register alias table: ARCH_REGS entries of phys_reg_t.
//   rd_addr/rd_data_c : combinational read ports
//   wr_en/addr/data   : two write ports, port 1 wins on the same address
//   load_en/load_data : bulk replace of the whole table (overrides writes)
//   tbl_next_c        : table contents after this cycle's writes, for bulk
//                       loading another instance
// Entry 0 is never written so x0 always reads p0.
module rat_table
  import rename_map_pkg::*;
#(
  parameter int unsigned RD_PORTS = RAT_RD_PORTS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [RD_PORTS-1:0][ARCH_REGS_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS-1:0][PHYS_REGS_ADDR_WIDTH-1:0] rd_data_c,
  input  logic [DISPATCH_WIDTH-1:0]            wr_en,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wr_data,
  input  logic                                 load_en,
  input  logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0] load_data,
  output logic [ARCH_REGS-1:0][PHYS_REGS_ADDR_WIDTH-1:0] tbl_next_c
);

  phys_reg_t [ARCH_REGS-1:0] tbl_q;

  // Next table: bulk load, else port 0 then port 1 so port 1 wins.
  always_comb begin
    tbl_next_c = tbl_q;
    if (load_en) begin
      tbl_next_c = load_data;
    end else begin
      for (int w = 0; w < int'(DISPATCH_WIDTH); w++) begin
        if (wr_en[1'(w)] && (wr_addr[1'(w)] != '0)) begin
          tbl_next_c[wr_addr[1'(w)]] = wr_data[1'(w)];
        end
      end
    end
    tbl_next_c[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_q <= '0;
    end else begin
      tbl_q <= tbl_next_c;
    end
  end

  // Read ports
  for (genvar r = 0; r < int'(RD_PORTS); r++) begin : g_rd
    assign rd_data_c[r] = tbl_q[rd_addr[r]];
  end

endmodule

// File: rtl/rename_map.sv
// 2-wide rename stage between the freelist and dispatch.
//   in_*            : decoded bundle, accepted all-or-nothing on in_ready
//   fl_num_free     : freelist occupancy; fl_pop_en/fl_pop_reg pop same cycle
//   fl_push_en/reg  : stale registers returned at commit
//   out_*           : renamed bundle, one-cycle latency, valid/ready
//   commit_*        : ROB retirement updates the committed RAT
//   flush           : restore speculative RAT from committed RAT
module rename_map
  import rename_map_pkg::*;
(
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DISPATCH_WIDTH-1:0]                           in_valid,
  output logic                                                in_ready,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] in_rs1,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] in_rs2,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] in_rd,
  input  logic [DISPATCH_WIDTH-1:0]                           in_rd_en,
  input  logic [FREE_CNT_WIDTH-1:0]                           fl_num_free,
  output logic [DISPATCH_WIDTH-1:0]                           fl_pop_en,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] fl_pop_reg,
  output logic [DISPATCH_WIDTH-1:0]                           fl_push_en,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] fl_push_reg,
  output logic [DISPATCH_WIDTH-1:0]                           out_valid,
  input  logic                                                out_ready,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_prs1,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_prs2,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_prd,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_stale_prd,
  output logic [DISPATCH_WIDTH-1:0]                           out_alloc,
  input  logic [DISPATCH_WIDTH-1:0]                           commit_en,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] commit_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_prd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_stale_prd,
  input  logic [DISPATCH_WIDTH-1:0]                           commit_alloc,
  input  logic                                                flush
);

  logic [DISPATCH_WIDTH-1:0]           alloc;
  logic [1:0]                          n_alloc;
  logic                                adv;
  logic                                fire;
  phys_reg_t [DISPATCH_WIDTH-1:0]      new_prd;
  arch_reg_t [RAT_RD_PORTS-1:0]        spec_rd_addr;
  phys_reg_t [RAT_RD_PORTS-1:0]        spec_rd;
  phys_reg_t [ARCH_REGS-1:0]           commit_next;
  logic [DISPATCH_WIDTH-1:0]           commit_we;
  rename_slot_t [DISPATCH_WIDTH-1:0]   slot_d;
  rename_slot_t [DISPATCH_WIDTH-1:0]   slot_q;
  logic [DISPATCH_WIDTH-1:0]           valid_q;
  phys_reg_t [RAT_RD_PORTS-1:0]        unused_commit_rd;
  phys_reg_t [ARCH_REGS-1:0]           unused_spec_next;

  // Handshake: all-or-nothing acceptance gated by freelist occupancy.
  always_comb begin
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      alloc[1'(i)] = in_valid[1'(i)] & in_rd_en[1'(i)] & (in_rd[1'(i)] != '0);
    end
    n_alloc   = {1'b0, alloc[0]} + {1'b0, alloc[1]};
    adv       = ~(|valid_q) | out_ready;
    in_ready  = rst & adv & ~flush & (fl_num_free >= FREE_CNT_WIDTH'(n_alloc));
    fire      = in_ready & (|in_valid);
    fl_pop_en = {DISPATCH_WIDTH{fire}} & alloc;
  end

  // Read ports: slot 0 rs1/rs2/rd, then slot 1 rs1/rs2/rd.
  assign spec_rd_addr = {in_rd[1], in_rs2[1], in_rs1[1], in_rd[0], in_rs2[0], in_rs1[0]};

  // Rename with intra-bundle bypass from slot 0's new destination.
  always_comb begin
    slot_d  = '0;
    new_prd = '0;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      if (alloc[1'(i)]) begin
        new_prd[1'(i)] = fl_pop_reg[1'(i)];
      end
    end
    slot_d[0].prs1      = spec_rd[0];
    slot_d[0].prs2      = spec_rd[1];
    slot_d[0].stale_prd = spec_rd[2];
    slot_d[0].prd       = new_prd[0];
    slot_d[0].alloc     = alloc[0];
    slot_d[1].prs1      = spec_rd[3];
    slot_d[1].prs2      = spec_rd[4];
    slot_d[1].stale_prd = spec_rd[5];
    slot_d[1].prd       = new_prd[1];
    slot_d[1].alloc     = alloc[1];
    if (alloc[0] && (in_rs1[1] == in_rd[0])) slot_d[1].prs1 = new_prd[0];
    if (alloc[0] && (in_rs2[1] == in_rd[0])) slot_d[1].prs2 = new_prd[0];
    if (alloc[0] && alloc[1] && (in_rd[1] == in_rd[0])) slot_d[1].stale_prd = new_prd[0];
  end

  // Speculative RAT; a flush reloads it from the committed RAT's next state.
  rat_table #(.RD_PORTS(RAT_RD_PORTS)) u_spec (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (spec_rd_addr),
    .rd_data_c  (spec_rd),
    .wr_en      ({DISPATCH_WIDTH{fire}} & alloc),
    .wr_addr    (in_rd),
    .wr_data    (new_prd),
    .load_en    (flush),
    .load_data  (commit_next),
    .tbl_next_c (unused_spec_next)
  );

  assign commit_we = commit_en & commit_alloc;

  rat_table #(.RD_PORTS(RAT_RD_PORTS)) u_commit (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    ('0),
    .rd_data_c  (unused_commit_rd),
    .wr_en      (commit_we),
    .wr_addr    (commit_rd),
    .wr_data    (commit_prd),
    .load_en    (1'b0),
    .load_data  ('0),
    .tbl_next_c (commit_next)
  );

  // Stale registers go back to the freelist; p0 is never freed.
  always_comb begin
    fl_push_reg = commit_stale_prd;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      fl_push_en[1'(i)] = rst & commit_we[1'(i)] & (commit_stale_prd[1'(i)] != '0);
    end
  end

  // Output register: load on fire, drain when the consumer takes it, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      slot_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fire) begin
      valid_q <= in_valid;
      slot_q  <= slot_d;
    end else if (adv) begin
      valid_q <= '0;
    end
  end

  always_comb begin
    out_valid = valid_q;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      out_prs1[1'(i)]      = slot_q[1'(i)].prs1;
      out_prs2[1'(i)]      = slot_q[1'(i)].prs2;
      out_prd[1'(i)]       = slot_q[1'(i)].prd;
      out_stale_prd[1'(i)] = slot_q[1'(i)].stale_prd;
      out_alloc[1'(i)]     = slot_q[1'(i)].alloc;
    end
  end

endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- 2-wide register rename stage sitting directly downstream of the physical-register freelist and upstream of dispatch/ROB.
- Each cycle it translates a decoded bundle's architectural rs1/rs2/rd to physical registers, popping new destinations from the freelist.
- Keeps a speculative RAT and a committed RAT, restoring the speculative one on flush.
- Returns stale physical registers to the freelist at commit.

Parameters:
- DISPATCH_WIDTH, 2, rename slots per cycle; logic is written for exactly 2.
- ARCH_REGS, 32, architectural registers; x0 is hardwired.
- PHYS_REGS, 64, physical registers.
- PHYS_REGS_ADDR_WIDTH, 6, log2(PHYS_REGS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  2  per-slot decoded instruction valid
- in_ready  out  1  bundle accepted this cycle when in_ready & |in_valid
- in_rs1, in_rs2, in_rd  in  2x5  architectural sources/destination
- in_rd_en  in  2  slot writes rd
- fl_num_free  in  7  free count from freelist
- fl_pop_en  out  2  freelist pop request
- fl_pop_reg  in  2x6  popped registers, combinational same cycle, positioned per pop_en
- fl_push_en  out  2  freelist push request
- fl_push_reg  out  2x6  registers being freed
- out_valid  out  2  renamed slot valid
- out_ready  in  1  downstream accepts
- out_prs1, out_prs2, out_prd, out_stale_prd  out  2x6  renamed operands
- out_alloc  out  2  slot allocated a new prd
- commit_en  in  2  ROB retires slot
- commit_rd  in  2x5  retiring architectural rd
- commit_prd  in  2x6  retiring physical rd
- commit_stale_prd  in  2x6  register to free
- commit_alloc  in  2  retiring slot had allocated
- flush  in  1  squash all speculative state

Behaviour:
- Reset (asynchronous, rst low): both RATs all zero (every arch reg maps to p0), out_valid=0, out_* = 0, fl_pop_en=0, fl_push_en=0.
- alloc[i] = in_valid[i] & in_rd_en[i] & (in_rd[i] != 0).
- n_alloc = popcount(alloc), 0..2.
- Stage advance: adv = !(|out_valid) | out_ready.
- in_ready = adv & !flush & (fl_num_free >= n_alloc). It is all-or-nothing; a bundle is never partially accepted.
- fire = in_ready & |in_valid.
- fl_pop_en[i] = fire & alloc[i]. It is combinational; no pop happens without fire.
- New prd for slot i is fl_pop_reg[i]. Slot 1 reads fl_pop_reg[1] even when only slot 1 allocates, matching the freelist's output packing.
- prd for a non-allocating slot is 0.
- Sources: prs = specRAT[rs], with arch 0 giving 0.
- Intra-bundle bypass: if alloc[0] and in_rs1[1] or in_rs2[1] equals in_rd[0], slot 1 uses slot 0's new prd.
- Stale: stale_prd[i] = specRAT[rd]. If alloc[0] & alloc[1] & rd0 == rd1, stale_prd[1] = slot 0's new prd.
- specRAT update on fire: write slot 0 then slot 1; slot 1 wins on the same rd.
- Output register: loaded on fire. If adv and no fire, out_valid is cleared. If !adv, it holds. Latency is 1 cycle input to output.
- Commit: commitRAT[commit_rd[i]] <= commit_prd[i] for commit_en[i] & commit_alloc[i]; slot 1 wins.
- Freeing: fl_push_en[i] = commit_en[i] & commit_alloc[i] & (commit_stale_prd[i] != 0), and fl_push_reg[i] = commit_stale_prd[i]. p0 is never pushed.
- Commit never modifies specRAT.
- Flush, taking priority over everything:
  - in_ready=0, so no pops.
  - out_valid cleared next edge.
  - Next edge, specRAT <= commitRAT including that cycle's commit writes.
  - Commits and pushes in the flush cycle still take effect.
  - Freelist pointer recovery is outside this block.
- Freelist short (fl_num_free < n_alloc): stall; specRAT and outputs are unchanged, apart from output drain.
- Reset mid-operation: all state returns to reset values immediately; pending output is lost.

Decomposition:
- The parameters package gains:
  - ARCH_REGS and ARCH_REGS_ADDR_WIDTH=5
  - a typedef phys_reg_t, logic [PHYS_REGS_ADDR_WIDTH-1:0]
  - a typedef rename_slot_t packing prs1/prs2/prd/stale_prd/alloc
- Sub-module rat_table: ARCH_REGS x phys_reg_t register file with 6 combinational read ports, 2 write ports (port 1 priority), and a bulk-load input from a second instance.
- Instantiate rat_table twice, as spec and commit.

Test Plan:
- Reset, then bundle {add x1,x2,x3; add x4,x1,x1}, fl_pop_reg={5,6}, num_free=63:
  - pop_en=11.
  - Next cycle: slot0 prd=5, prs=0/0, stale=0.
  - Slot1 prd=6, prs1=prs2=5, stale=0.
- Both slots write x7 with pops {8,9}:
  - stale_prd[1]=8, out_prd={8,9}.
  - Later a lone read of x7 gives prs1=9.
- fl_num_free=1 with n_alloc=2:
  - in_ready=0, pop_en=00, specRAT unchanged.
  - Raise num_free to 2: the bundle fires.
- out_ready=0 with out_valid set: in_ready=0 and outputs held stable for 3 cycles; releasing out_ready accepts the next bundle the same cycle.
- Rename x1->p5, commit x1/p5/stale p0:
  - no push, since stale is p0.
  - Rename x1->p10, then flush: next cycle a read of x1 gives p5.
  - A commit with stale p5 pushes p5 (push_en=01).
- Assert rst low asynchronously mid-stream while out_valid=11: out_valid drops without a clock edge and all RAT reads return 0.
